// File: rtl/alu_seq.sv
// alu_seq: handshaked multi-cycle ALU. Simple ops finish in one cycle.
// Multiply runs radix-2 shift-add and divide/remainder runs restoring
// division, one bit per cycle. The result is held in DONE until the
// consumer takes it.
module alu_seq #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [6:0]       operation,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_zero,
  output logic             flag_carry,
  output logic             flag_ovf,
  output logic             flag_dz,
  output logic             flag_ill
);

  localparam logic [6:0] OP_ADD  = 7'd0;
  localparam logic [6:0] OP_SUB  = 7'd1;
  localparam logic [6:0] OP_MUL  = 7'd2;
  localparam logic [6:0] OP_DIVU = 7'd3;
  localparam logic [6:0] OP_AND  = 7'd4;
  localparam logic [6:0] OP_OR   = 7'd5;
  localparam logic [6:0] OP_XOR  = 7'd6;
  localparam logic [6:0] OP_NOR  = 7'd7;
  localparam logic [6:0] OP_SLL  = 7'd8;
  localparam logic [6:0] OP_SRL  = 7'd9;
  localparam logic [6:0] OP_SRA  = 7'd10;
  localparam logic [6:0] OP_REMU = 7'd11;

  localparam logic [SHW-1:0] LAST_IT = SHW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;

  state_e             state_q, state_d;
  logic [SHW-1:0]     cnt_q, cnt_d;
  logic               is_rem_q, is_rem_d;
  logic [WIDTH-1:0]   opa_q, opa_d;     // multiplicand
  logic [WIDTH-1:0]   opb_q, opb_d;     // divisor
  logic [2*WIDTH-1:0] prod_q, prod_d;   // {partial high, remaining multiplier}
  logic [WIDTH-1:0]   rem_q, rem_d;     // partial remainder
  logic [WIDTH-1:0]   quo_q, quo_d;     // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0]   res_q, res_d;
  logic               fz_q, fz_d, fc_q, fc_d, fo_q, fo_d, fdz_q, fdz_d, fill_q, fill_d;

  // ---------------------------------------------------------------
  // Single-cycle datapath, evaluated straight from the request inputs
  // ---------------------------------------------------------------
  logic [WIDTH:0]   s_sum;
  logic [WIDTH-1:0] s_bx, s_res;
  logic [SHW-1:0]   s_sh;
  logic             s_c, s_o, s_dz, s_ill;

  // Result and flags for every op that completes on the accepting edge
  always_comb begin
    s_sum = '0;
    s_bx  = b;
    s_res = '0;
    s_c   = 1'b0;
    s_o   = 1'b0;
    s_dz  = 1'b0;
    s_ill = 1'b0;
    s_sh  = b[SHW-1:0];
    case (operation)
      OP_ADD, OP_SUB: begin
        // Subtract as a + ~b + 1 so bit WIDTH is the no-borrow carry
        s_bx  = (operation == OP_SUB) ? ~b : b;
        s_sum = {1'b0, a} + {1'b0, s_bx} + {{WIDTH{1'b0}}, (operation == OP_SUB)};
        s_res = s_sum[WIDTH-1:0];
        s_c   = s_sum[WIDTH];
        s_o   = (a[WIDTH-1] == s_bx[WIDTH-1]) && (s_res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_MUL:  s_res = '0;              // iterative path
      // Divide/remainder only take this path when b == 0
      OP_DIVU: begin s_res = '1; s_dz = 1'b1; end
      OP_REMU: begin s_res = a;  s_dz = 1'b1; end
      OP_AND:  s_res = a & b;
      OP_OR:   s_res = a | b;
      OP_XOR:  s_res = a ^ b;
      OP_NOR:  s_res = ~(a | b);
      OP_SLL:  s_res = a << s_sh;
      OP_SRL:  s_res = a >> s_sh;
      OP_SRA:  s_res = $unsigned($signed(a) >>> s_sh);
      default: s_ill = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------
  // Iteration steps
  // ---------------------------------------------------------------
  logic [WIDTH:0]     m_sum;
  logic [2*WIDTH-1:0] m_next;

  // One shift-add multiply step: add multiplicand on LSB, shift right
  always_comb begin
    m_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, opa_q} : '0);
    m_next = {m_sum, prod_q[WIDTH-1:1]};
  end

  logic [WIDTH:0]   d_sh;
  logic             d_ge;
  logic [WIDTH-1:0] d_rem, d_quo, d_fin;

  // One restoring-division step: shift in next dividend bit, trial subtract
  always_comb begin
    d_sh  = {rem_q, quo_q[WIDTH-1]};
    d_ge  = (d_sh >= {1'b0, opb_q});
    d_rem = d_ge ? WIDTH'(d_sh - {1'b0, opb_q}) : d_sh[WIDTH-1:0];
    d_quo = {quo_q[WIDTH-2:0], d_ge};
    d_fin = is_rem_q ? d_rem : d_quo;
  end

  // ---------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------
  // Next-state, operand capture and result/flag registration
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_rem_d = is_rem_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    prod_d   = prod_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    res_d    = res_q;
    fz_d     = fz_q;
    fc_d     = fc_q;
    fo_d     = fo_q;
    fdz_d    = fdz_q;
    fill_d   = fill_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          opa_d    = a;
          opb_d    = b;
          cnt_d    = '0;
          is_rem_d = (operation == OP_REMU);
          if (operation == OP_MUL) begin
            prod_d  = {{WIDTH{1'b0}}, b};
            state_d = MUL;
          end else if ((operation == OP_DIVU || operation == OP_REMU) && (b != '0)) begin
            rem_d   = '0;
            quo_d   = a;
            state_d = DIV;
          end else begin
            res_d   = s_res;
            fz_d    = (s_res == '0);
            fc_d    = s_c;
            fo_d    = s_o;
            fdz_d   = s_dz;
            fill_d  = s_ill;
            state_d = DONE;
          end
        end
      end
      MUL: begin
        prod_d = m_next;
        cnt_d  = cnt_q + SHW'(1);
        if (cnt_q == LAST_IT) begin
          res_d   = m_next[WIDTH-1:0];
          fz_d    = (m_next[WIDTH-1:0] == '0);
          fc_d    = |m_next[2*WIDTH-1:WIDTH];
          fo_d    = 1'b0;
          fdz_d   = 1'b0;
          fill_d  = 1'b0;
          state_d = DONE;
        end
      end
      DIV: begin
        rem_d = d_rem;
        quo_d = d_quo;
        cnt_d = cnt_q + SHW'(1);
        if (cnt_q == LAST_IT) begin
          res_d   = d_fin;
          fz_d    = (d_fin == '0);
          fc_d    = 1'b0;
          fo_d    = 1'b0;
          fdz_d   = 1'b0;
          fill_d  = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        // No accept from DONE: in_ready only returns after the hop to IDLE
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any operation in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      is_rem_q <= 1'b0;
      opa_q    <= '0;
      opb_q    <= '0;
      prod_q   <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      res_q    <= '0;
      fz_q     <= 1'b0;
      fc_q     <= 1'b0;
      fo_q     <= 1'b0;
      fdz_q    <= 1'b0;
      fill_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_rem_q <= is_rem_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      prod_q   <= prod_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      res_q    <= res_d;
      fz_q     <= fz_d;
      fc_q     <= fc_d;
      fo_q     <= fo_d;
      fdz_q    <= fdz_d;
      fill_q   <= fill_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign result     = res_q;
  assign flag_zero  = fz_q;
  assign flag_carry = fc_q;
  assign flag_ovf   = fo_q;
  assign flag_dz    = fdz_q;
  assign flag_ill   = fill_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vectors against a behavioural model, with a
// per-cycle compare process and hand-computed literal expectations.
module tb_alu_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] a, b, result;
  logic [6:0]   operation;
  logic         flag_zero, flag_carry, flag_ovf, flag_dz, flag_ill;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .operation(operation),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result),
    .flag_zero(flag_zero), .flag_carry(flag_carry), .flag_ovf(flag_ovf),
    .flag_dz(flag_dz), .flag_ill(flag_ill)
  );

  always #5 clk = ~clk;

  // fl = {zero, carry, ovf, dz, ill}
  typedef struct packed {
    logic [W-1:0] res;
    logic [4:0]   fl;
    logic [7:0]   lat;
  } exp_t;

  int checks = 0, errors = 0;
  int cyc = 0, due = 0, acc_cyc = 0, acc_cnt = 0, done_cnt = 0, last_lat = 0;
  logic busy = 1'b0, pend = 1'b0, seen = 1'b0;
  logic [W-1:0] last_res;
  logic [4:0]   last_fl;
  exp_t cur;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // What the ALU must return, straight from the opcode definitions
  function automatic exp_t model(input logic [6:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    longint unsigned ux, uy, p;
    longint sa, sb, sr;
    logic signed [W-1:0] t;
    int sh;
    logic c, o, dz, ill;
    ux = x; uy = y; sa = $signed(x); sb = $signed(y);
    sh = int'(y[4:0]);
    e.res = '0; e.lat = 8'd1; c = 0; o = 0; dz = 0; ill = 0; sr = 0; p = 0;
    case (op)
      7'd0: begin p = ux + uy; e.res = x + y; c = p[32]; sr = sa + sb; t = sr[W-1:0]; o = (longint'(t) != sr); end
      7'd1: begin e.res = x - y; c = (x >= y); sr = sa - sb; t = sr[W-1:0]; o = (longint'(t) != sr); end
      7'd2: begin p = ux * uy; e.res = p[W-1:0]; c = (p[63:32] != 0); e.lat = 8'(W + 1); end
      7'd3: if (y == 0) begin e.res = '1; dz = 1; end else begin e.res = x / y; e.lat = 8'(W + 1); end
      7'd11: if (y == 0) begin e.res = x; dz = 1; end else begin e.res = x % y; e.lat = 8'(W + 1); end
      7'd4: e.res = x & y;
      7'd5: e.res = x | y;
      7'd6: e.res = x ^ y;
      7'd7: e.res = ~(x | y);
      7'd8: e.res = x << sh;
      7'd9: e.res = x >> sh;
      7'd10: e.res = $signed(x) >>> sh;
      default: ill = 1;
    endcase
    e.fl = {(e.res == 0), c, o, dz, ill};
    return e;
  endfunction

  // Per-cycle compare: handshake readiness, latency, held result and flags
  initial forever begin
    @(negedge clk);
    if (rst) begin
      busy = 1'b0;
      pend = 1'b0;
    end else begin
      cyc++;
      chk("in_ready", in_ready, !busy);
      chk("out_valid", out_valid, pend && (cyc >= due));
      if (out_valid && pend) begin
        if (!seen) begin seen = 1'b1; last_lat = cyc - acc_cyc; end
        chk("result", result, cur.res);
        chk("flags", {flag_zero, flag_carry, flag_ovf, flag_dz, flag_ill}, cur.fl);
        if (out_ready) begin
          last_res = result;
          last_fl  = {flag_zero, flag_carry, flag_ovf, flag_dz, flag_ill};
          pend = 1'b0;
          busy = 1'b0;
          done_cnt++;
        end
      end else if (in_valid && !busy) begin
        cur = model(operation, a, b);
        pend = 1'b1;
        busy = 1'b1;
        seen = 1'b0;
        acc_cyc = cyc;
        due = cyc + int'(cur.lat);
        acc_cnt++;
      end
    end
  end

  // Present a request until accepted, then scramble the inputs
  task automatic issue(input logic [6:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    int start = acc_cnt;
    int n = 0;
    operation = op; a = x; b = y; in_valid = 1'b1;
    while (acc_cnt == start && n < 100) begin @(posedge clk); #1; n++; end
    chk("accept_timeout", (acc_cnt != start), 1);
    in_valid = 1'b0; a = $urandom; b = $urandom; operation = 7'h7F;
  endtask

  task automatic wait_done(input int budget);
    int start = done_cnt;
    int n = 0;
    while (done_cnt == start && n < budget) begin @(posedge clk); #1; n++; end
    chk("done_timeout", (done_cnt != start), 1);
  endtask

  task automatic run(input logic [6:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    issue(op, x, y);
    wait_done(100);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; operation = '0;
    @(posedge clk); #1;
    chk("rst in_ready", in_ready, 1);
    chk("rst out_valid", out_valid, 0);
    chk("rst result", result, 0);
    chk("rst flags", {flag_zero, flag_carry, flag_ovf, flag_dz, flag_ill}, 0);
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b1;

    run(7'd0, 32'hFFFF_FFFF, 32'd1);
    chk("add wrap res", last_res, 32'h0);
    chk("add wrap fl", last_fl, 5'b11000);
    chk("add lat", last_lat, 1);
    run(7'd0, 32'h7FFF_FFFF, 32'd1);
    chk("add ovf res", last_res, 32'h8000_0000);
    chk("add ovf fl", last_fl, 5'b00100);

    run(7'd8, 32'h8000_0010, 32'h24);
    chk("sll res", last_res, 32'h0000_0100);
    run(7'd9, 32'h8000_0010, 32'h24);
    chk("srl res", last_res, 32'h0800_0001);
    run(7'd10, 32'h8000_0010, 32'h24);
    chk("sra res", last_res, 32'hF800_0001);
    run(7'd8, 32'd1, 32'hFFFF_FFE1);
    chk("sll upper b ignored", last_res, 32'd2);

    run(7'd1, 32'd5, 32'd7);
    chk("sub borrow fl", last_fl, 5'b00000);
    run(7'd1, 32'd7, 32'd7);
    chk("sub eq fl", last_fl, 5'b11000);
    run(7'd1, 32'h8000_0000, 32'd1);
    run(7'd4, 32'hF0F0_1234, 32'h0FF0_FFFF);
    run(7'd5, 32'hF000_0000, 32'h0000_000F);
    run(7'd7, 32'hFFFF_0000, 32'h0000_FFFF);
    chk("nor zero fl", last_fl, 5'b10000);

    // Multiply with an ignored request while busy
    issue(7'd2, 32'h0001_0000, 32'h0001_0001);
    repeat (3) begin @(posedge clk); #1; end
    operation = 7'd0; a = 32'd1; b = 32'd1; in_valid = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    in_valid = 1'b0;
    wait_done(100);
    chk("mul res", last_res, 32'h0001_0000);
    chk("mul fl", last_fl, 5'b01000);
    chk("mul lat", last_lat, 33);
    run(7'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run(7'd2, 32'd12345, 32'd678);

    run(7'd3, 32'd100, 32'd7);
    chk("divu res", last_res, 32'd14);
    chk("divu lat", last_lat, 33);
    run(7'd11, 32'd100, 32'd7);
    chk("remu res", last_res, 32'd2);
    run(7'd3, 32'd100, 32'd0);
    chk("divu0 res", last_res, 32'hFFFF_FFFF);
    chk("divu0 fl", last_fl, 5'b00010);
    chk("divu0 lat", last_lat, 1);
    run(7'd11, 32'd100, 32'd0);
    chk("remu0 res", last_res, 32'd100);
    chk("remu0 fl", last_fl, 5'b00010);
    run(7'd3, 32'hFFFF_FFFF, 32'd1);
    run(7'd11, 32'h1234_5678, 32'h0000_1000);
    run(7'd3, 32'd3, 32'd9);

    // Backpressure: result must sit unchanged while out_ready is low
    out_ready = 1'b0;
    issue(7'd6, 32'h0000_F0F0, 32'h0000_FFFF);
    repeat (10) begin @(posedge clk); #1; end
    out_ready = 1'b1;
    wait_done(20);
    chk("xor res", last_res, 32'h0000_0F0F);

    run(7'h7F, 32'd5, 32'd5);
    chk("ill res", last_res, 32'h0);
    chk("ill fl", last_fl, 5'b10001);

    // Reset in the middle of a divide
    issue(7'd3, 32'd100, 32'd7);
    repeat (10) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    chk("midrst out_valid", out_valid, 0);
    chk("midrst in_ready", in_ready, 1);
    chk("midrst result", result, 0);
    chk("midrst flags", {flag_zero, flag_carry, flag_ovf, flag_dz, flag_ill}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    run(7'd0, 32'd2, 32'd3);
    chk("post rst add", last_res, 32'd5);
    chk("post rst lat", last_lat, 1);
    repeat (3) begin @(posedge clk); #1; end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked, multi-cycle successor to the team's combinational 32-bit ALU.
- Keeps the 7-bit opcode map and adds remainder, a true logical/arithmetic shift split, status flags and iterative multiply/divide.
- Sits between the decode stage and writeback. It accepts one operation at a time over a valid/ready pair and holds its result until the consumer takes it.

Parameters:
- WIDTH, 32: operand/result width. Must be at least 4 and a power of two.
- SHW, $clog2(WIDTH): shift-amount bits taken from b. Derived; not overridden.

Ports:
- clk  in  1: rising-edge clock.
- rst  in  1: asynchronous, active-high reset.
- in_valid  in  1: operation request.
- in_ready  out  1: block can accept a request.
- a  in  WIDTH: operand A.
- b  in  WIDTH: operand B.
- operation  in  7: opcode.
- out_valid  out  1: result and flags are valid.
- out_ready  in  1: consumer accepts the result.
- result  out  WIDTH: result.
- flag_zero  out  1: result == 0.
- flag_carry  out  1: add carry-out; sub no-borrow (a >= b, unsigned); mul upper half nonzero.
- flag_ovf  out  1: signed overflow for add/sub; 0 for all other ops.
- flag_dz  out  1: divide or remainder by zero.
- flag_ill  out  1: unknown opcode.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high. Reset drives state to IDLE and every output to 0, except in_ready, which is 1.
- Opcodes:
  - 0 add, 1 sub, 2 mul (low WIDTH bits, unsigned), 3 divu, 4 and, 5 or, 6 xor, 7 nor.
  - 8 sll, 9 srl (logical), 10 sra (arithmetic), 11 remu.
  - Any other opcode is illegal.
- Shifts: use b[SHW-1:0] only; upper bits of b are ignored.
- Handshake:
  - A request is accepted on a rising edge with in_valid && in_ready.
  - a, b and operation are captured at that edge. The inputs may change afterwards.
  - in_ready = (state == IDLE). It is combinational from state only and never depends on in_valid.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE, accept, op in {0,1,4..10}, illegal opcode, or divide-by-zero: compute the result, register it, go to DONE. out_valid is 1 one cycle after the accepting edge.
  - IDLE, accept, op 2: go to MUL. Radix-2 shift-add, one bit per cycle, iteration counter 0..WIDTH-1.
  - IDLE, accept, op 3 or 11 with b != 0: go to DIV. Restoring division, one quotient bit per cycle from the MSB.
  - MUL/DIV: after WIDTH iterations, go to DONE. out_valid is 1 exactly WIDTH+1 cycles after the accepting edge.
  - DONE: out_valid = 1; result and flags are stable. On out_valid && out_ready, go to IDLE. in_ready rises on the following cycle (no same-cycle accept from DONE).
- Back-to-back throughput: simple ops run one per 2 cycles when out_ready is held high.
- Divide by zero:
  - divu returns all ones; remu returns a.
  - flag_dz = 1, latency 1, no iteration.
- Illegal opcode: result 0, flag_ill = 1, flag_zero = 1, latency 1.
- Width rules:
  - add/sub are computed WIDTH+1 wide. The carry is bit WIDTH; for sub this bit is the inverted borrow.
  - flag_ovf = (sign a == sign b') && (sign res != sign a), where b' = b for add and ~b for sub.
  - mul keeps a 2*WIDTH product internally; flag_carry = |product[2W-1:W].
- flag_zero is evaluated on the final result for every op.
- Non-applicable flags are 0.
- Reset mid-operation (MUL/DIV/DONE): the operation is abandoned, all outputs clear per the reset values, and no stale result appears after reset is released.
- in_valid while busy: ignored; the request is not captured and must be held by the producer.
- out_ready low: the result is held indefinitely in DONE with flags stable.

Test Plan:
- Reset then add with WIDTH=32: a=0xFFFFFFFF, b=1, op0 -> out_valid at +1 cycle; result=0, zero=1, carry=1, ovf=0. Then a=0x7FFFFFFF, b=1 -> result 0x80000000, ovf=1.
- Shifts: a=0x80000010, b=0x24, op8/9/10 (shift by 4) -> 0x00000100, 0x08000001, 0xF8000001 respectively.
- Multiply: a=0x00010000, b=0x00010001, op2 -> out_valid exactly 33 cycles after accept; result 0x00010000, carry=1. During the operation in_ready=0, and an in_valid pulse is ignored.
- Divide: a=100, b=7, op3 -> 14 after 33 cycles; op11 -> 2. With b=0: op3 -> 0xFFFFFFFF, dz=1; op11 -> 100, dz=1; both at +1 cycle.
- Backpressure and illegal opcode: hold out_ready=0 for 10 cycles after op6 (a=0xF0F0, b=0xFFFF) -> result 0x0F0F, held stable, in_ready=0. Release -> in_ready=1 next cycle. Then op=0x7F -> result 0, ill=1.
- Reset mid-divide: assert rst at cycle 10 of a DIV -> all outputs 0 and in_ready=1 immediately. After release, an add 2+3 returns 5 with no stale out_valid.
